// File: rtl/button_debouncer.sv
// Push-button front end: synchronises the raw pad into clk and filters contact
// bounce so downstream logic sees one clean, registered level change per press.
module button_debouncer #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_out,
    output logic busy
);

    localparam int unsigned CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        LOW      = 2'd0,
        ARM_HIGH = 2'd1,
        HIGH     = 2'd2,
        ARM_LOW  = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync;
    logic                   btn_sync;

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             btn_out_n;
    logic             busy_n;

    // Shift chain; only the last stage is allowed past this point.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], btn_in};
        end
    end

    assign btn_sync = sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= LOW;
            cnt     <= '0;
            btn_out <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            btn_out <= btn_out_n;
            busy    <= busy_n;
        end
    end

    // An opposite sample aborts qualification even on the terminal-count cycle.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            LOW: begin
                if (btn_sync) begin
                    state_n = ARM_HIGH;
                    cnt_n   = '0;
                end
            end
            ARM_HIGH: begin
                if (!btn_sync) begin
                    state_n = LOW;
                    cnt_n   = '0;
                end else if (cnt == CNT_TERM) begin
                    state_n = HIGH;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            HIGH: begin
                if (!btn_sync) begin
                    state_n = ARM_LOW;
                    cnt_n   = '0;
                end
            end
            ARM_LOW: begin
                if (btn_sync) begin
                    state_n = HIGH;
                    cnt_n   = '0;
                end else if (cnt == CNT_TERM) begin
                    state_n = LOW;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = LOW;
                cnt_n   = '0;
            end
        endcase

        // Outputs follow the next state so they update on the transition edge.
        btn_out_n = (state_n == HIGH) || (state_n == ARM_LOW);
        busy_n    = (state_n == ARM_HIGH) || (state_n == ARM_LOW);
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: directed scenarios plus random bursts, checked
// against a run-length reference model of the debounce rules.
module tb_button_debouncer;

    localparam int unsigned SS = 2;
    localparam int unsigned DC = 4;

    logic clk;
    logic rst;
    logic btn_in;
    logic btn_out;
    logic busy;

    int unsigned total;
    int unsigned passed;

    // Reference model: delay line of synchronised samples and a run length of
    // consecutive samples that disagree with the accepted level.
    bit          hist[$];
    int unsigned run;
    logic        m_out;
    logic        m_busy;

    button_debouncer #(
        .SYNC_STAGES     (SS),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_in  (btn_in),
        .btn_out (btn_out),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < int'(SS); i++) hist.push_back(1'b0);
        run    = 0;
        m_out  = 1'b0;
        m_busy = 1'b0;
    endtask

    task automatic model_edge(input logic v);
        bit s;
        hist.push_back(v);
        s = hist.pop_front();
        if (s != m_out) begin
            run++;
            if (run == DC + 1) begin
                m_out = s;
                run   = 0;
            end
        end else begin
            run = 0;
        end
        m_busy = (run > 0);
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    // Drive one input value for one clock, then compare against the model.
    task automatic step(input logic v);
        btn_in = v;
        @(posedge clk);
        model_edge(v);
        #1;
        check("btn_out", btn_out, m_out);
        check("busy", busy, m_busy);
    endtask

    initial begin
        bit saw_busy;
        logic v;
        int unsigned len;

        total  = 0;
        passed = 0;
        rst    = 1'b1;
        btn_in = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_btn_out", btn_out, 1'b0);
        check("reset_busy", busy, 1'b0);
        #2 rst = 1'b0;

        // Idle after reset
        for (int i = 0; i < 20; i++) begin
            step(1'b0);
            check("idle_btn_out", btn_out, 1'b0);
        end

        // Clean press: busy from edge 3, level accepted on edge 7
        for (int i = 1; i <= 10; i++) begin
            step(1'b1);
            if (i == 2) check("press_busy_e2", busy, 1'b0);
            if (i == 3) check("press_busy_e3", busy, 1'b1);
            if (i == 6) check("press_out_e6", btn_out, 1'b0);
            if (i == 7) check("press_out_e7", btn_out, 1'b1);
            if (i == 7) check("press_busy_e7", busy, 1'b0);
        end

        // Clean release
        for (int i = 1; i <= 10; i++) begin
            step(1'b0);
            if (i == 6) check("release_out_e6", btn_out, 1'b1);
            if (i == 7) check("release_out_e7", btn_out, 1'b0);
        end

        // Bouncy press: 1,1,1,0,1 then held; rises 7 edges after the last 0->1
        step(1'b1); step(1'b1); step(1'b1); step(1'b0);
        for (int i = 5; i <= 14; i++) begin
            step(1'b1);
            if (i < 11) check("bounce_out_low", btn_out, 1'b0);
            if (i == 11) check("bounce_out_e11", btn_out, 1'b1);
        end

        // Glitches in HIGH: 1-cycle and 4-cycle low pulses are filtered
        saw_busy = 1'b0;
        step(1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1);
            if (busy) saw_busy = 1'b1;
            check("glitch1_out", btn_out, 1'b1);
        end
        check("glitch1_busy_seen", saw_busy, 1'b1);
        saw_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1'b0);
            if (busy) saw_busy = 1'b1;
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b1);
            if (busy) saw_busy = 1'b1;
            check("glitch4_out", btn_out, 1'b1);
        end
        check("glitch4_busy_seen", saw_busy, 1'b1);
        check("glitch4_busy_end", busy, 1'b0);

        // Back to LOW, then reset mid-qualification (ARM_HIGH, cnt=2)
        for (int i = 0; i < 10; i++) step(1'b0);
        for (int i = 0; i < 5; i++) step(1'b1);
        check("pre_rst_busy", busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_out", btn_out, 1'b0);
        check("async_rst_busy", busy, 1'b0);
        model_reset();
        @(posedge clk);
        #3 rst = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            step(1'b1);
            if (i == 6) check("rst_press_out_e6", btn_out, 1'b0);
            if (i == 7) check("rst_press_out_e7", btn_out, 1'b1);
        end

        // Random bursts of mixed lengths around the qualification window
        for (int b = 0; b < 300; b++) begin
            v   = logic'($urandom_range(0, 1));
            len = $urandom_range(1, 9);
            for (int i = 0; i < int'(len); i++) step(v);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/button_debouncer.md
# button_debouncer

Debounced front end for a single mechanical push-button. It synchronises the raw asynchronous pad signal into the `clk` domain and filters contact bounce with a counter-qualified state machine. It drives a clean, glitch-free level into the edge detector stage directly downstream, which converts each accepted press into a one-cycle pulse.

## Interface

**Parameters**
- `SYNC_STAGES`, default 2: number of synchroniser flops. Legal values are 2 or more.
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable `clk` cycles required to accept a level change (10 ms at 100 MHz). Legal values are 1 or more.

**Ports**
- `clk`  in  1: system clock; all state updates on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `btn_in`  in  1: raw button pad signal; asynchronous to `clk` and bouncy.
- `btn_out`  out  1: debounced, registered level. Feeds the edge detector's input.
- `busy`  out  1: registered; high while a candidate level change is being qualified.

## Operation

**Synchroniser**
- `SYNC_STAGES` flops form a shift chain. `btn_sync` is the last stage.
- Only `btn_sync` is used beyond the chain; `btn_in` is never read directly.

**Counter**
- `cnt` is `$clog2(DEBOUNCE_CYCLES)` bits wide, with a minimum of 1 bit.
- It counts 0 .. DEBOUNCE_CYCLES-1 and never wraps; the terminal value forces a state exit.

**State machine (4 states)**
- `LOW`: `btn_out`=0, `busy`=0.
  - If `btn_sync`=1, go to `ARM_HIGH` with `cnt`<=0.
- `ARM_HIGH`: `btn_out`=0, `busy`=1.
  - If `btn_sync`=0, go to `LOW` (abort) with `cnt`<=0.
  - Else if `cnt`==DEBOUNCE_CYCLES-1, go to `HIGH`.
  - Else `cnt`<=`cnt`+1.
- `HIGH`: `btn_out`=1, `busy`=0.
  - If `btn_sync`=0, go to `ARM_LOW` with `cnt`<=0.
- `ARM_LOW`: `btn_out`=1, `busy`=1.
  - If `btn_sync`=1, go to `HIGH` (abort) with `cnt`<=0.
  - Else if `cnt`==DEBOUNCE_CYCLES-1, go to `LOW`.
  - Else `cnt`<=`cnt`+1.
- Abort has priority over terminal count. If the opposite sample arrives on the terminal cycle, the change is rejected.
- `btn_out` and `busy` are registered and update on the same edge as the state transition. There is no combinational path from `btn_in` to any output.
- Any bounce during an ARM state restarts qualification from zero on the next accepted candidate.
- Pulses shorter than DEBOUNCE_CYCLES+1 synchronised cycles never change `btn_out`.

**Reset**
- Asynchronous and immediate, with no clock edge required.
- Reset values: all synchroniser flops 0, state `LOW`, `cnt` 0, `btn_out` 0, `busy` 0.
- Reset asserted mid-qualification discards the count.
- If `btn_in` is held high through reset release, it is treated as a fresh press. `btn_out` rises after the normal latency, and downstream sees one press pulse.

## Timing

**Latency**
- Let edge 1 be the first rising `clk` edge that samples `btn_in` at its new, thereafter stable value.
- `btn_out` changes on edge SYNC_STAGES+DEBOUNCE_CYCLES+1. Press and release latencies are identical.
- Defaults: 2+1_000_000+1 edges.

**`busy`**
- Rises on edge SYNC_STAGES+1.
- Falls on the same edge that `btn_out` changes, or on the abort edge.

**Throughput**
- One level change is accepted per qualification window.
- Changes shorter than the window are filtered.

**Metastability**
- Stage 1 of the synchroniser may go metastable. Downstream logic sees only stage SYNC_STAGES.

## Test plan

All scenarios use SYNC_STAGES=2 and DEBOUNCE_CYCLES=4, for a latency of 7 edges.

1. **Reset:** assert `rst` with `btn_in`=0, release, run 20 cycles -> `btn_out`=0 and `busy`=0 throughout.
2. **Clean press:** `btn_in` 0->1, held -> `busy`=1 from edge 3, `btn_out`=1 exactly at edge 7, `busy`=0 at edge 7.
3. **Bouncy press:** `btn_in` = 1,1,1,0,1 then held 1 (one value per cycle) -> `btn_out` stays 0 through the bounce, then rises 7 edges after the final 0->1 sample, never earlier.
4. **Clean release from `HIGH`:** `btn_in` 1->0, held -> `btn_out`=0 exactly at edge 7.
5. **Glitch filtering:** a 1-cycle and a 4-cycle low pulse while in `HIGH` -> `btn_out` remains 1. Each glitch produces a `busy` pulse, and the state returns to `HIGH`.
6. **Reset mid-operation:**
   - Assert `rst` asynchronously (between clock edges) while in `ARM_HIGH` with `cnt`=2 -> `btn_out`=0 and `busy`=0 immediately, without a clock edge.
   - Release with `btn_in` held 1 -> `btn_out`=1 at edge 7 after release.
